gray_sequence_monitor: RTL
==========================

# gray_sequence_monitor

Downstream consumer of the parameterised Gray counter. It samples the counter's Gray-coded output and decodes it to binary. It checks that successive samples advance by exactly one count or hold, and tracks lock, wrap-around and error statistics. Sits between the Gray counter and any logic that needs a verified binary count.

## Interface
- N_Bits, 5, width of Gray input and binary output (2..16)
- LOCK_LEN, 4, consecutive good advances required to assert locked (1..15)
- ERR_W, 8, width of saturating error counter
- Clock  input  1  rising-edge clock, shared with the Gray counter
- Clear  input  1  synchronous, active-high reset
- sample_en  input  1  gray_in is sampled on a rising edge when high
- gray_in  input  [1:N_Bits]  Gray code; bit 1 is MSB, same ordering as counter q
- bin_out  output  [1:N_Bits]  registered binary decode of last sample; bit 1 is MSB
- bin_valid  output  1  one-cycle pulse: bin_out updated
- step_err  output  1  one-cycle pulse: illegal step detected
- wrap  output  1  one-cycle pulse: legal advance from all-ones to zero
- locked  output  1  level: LOCK_LEN consecutive good advances seen since last error or Clear
- err_count  output  [ERR_W-1:0]  saturating count of step errors

## Operation
- Decode: b[1]=g[1]; b[i]=b[i-1]^g[i] for i=2..N_Bits.
- prev holds the binary value of the last accepted sample.
- step = (b − prev) mod 2^N_Bits.
- Step classes:
  - step==1: advance
  - step==0: hold
  - any other value: error
- FSM states: SYNC, ACQUIRE, LOCKED. Encoding is free.
- SYNC (after Clear):
  - On sample_en: load prev=b, bin_out=b, pulse bin_valid.
  - No step check, no wrap. Go to ACQUIRE with good_cnt=0.
- ACQUIRE, on sample_en:
  - Advance: good_cnt+1. When good_cnt reaches LOCK_LEN, go to LOCKED and assert locked.
  - Hold: no change to good_cnt.
  - Error: pulse step_err, err_count+1 (saturating), good_cnt=0, stay in ACQUIRE.
- LOCKED, on sample_en:
  - Advance or hold: stay in LOCKED.
  - Error: pulse step_err, err_count+1, deassert locked, go to ACQUIRE with good_cnt=0.
- In ACQUIRE and LOCKED, every sample_en (any class):
  - prev=b, bin_out=b, pulse bin_valid. After an error the monitor re-references to the new value.
- wrap pulses only on an advance with prev = all ones and b = 0. It can pulse in ACQUIRE or LOCKED.
- err_count holds at 2^ERR_W−1 once saturated. It is cleared only by Clear.
- sample_en low: all state holds; all pulses low.

## Timing
- All outputs registered. A sample on edge k is reflected in bin_out, bin_valid, step_err, wrap and locked after edge k. Latency is 1 cycle.
- Pulses are high for exactly one cycle per sampled edge. Back-to-back sample_en gives back-to-back pulses.
- Reset values, on Clear high at an edge:
  - FSM=SYNC, bin_out=0, prev=0, good_cnt=0
  - bin_valid=0, step_err=0, wrap=0, locked=0, err_count=0
- Clear has priority over sample_en on the same edge. The sample is discarded.
- Clear asserted mid-lock: locked drops after that edge. The next sample is treated as a SYNC load, with no error.
- Error and wrap cannot coincide: wrap requires an advance.
- With LOCK_LEN=1, a single advance in ACQUIRE asserts locked after the same edge.

## Test plan
Each scenario uses N_Bits=5, LOCK_LEN=4 unless noted.

1. Lock-up: Clear, then drive the counter sequence 00000,00001,00011,00010,00110 with sample_en=1 every cycle.
   - bin_out = 0,1,2,3,4.
   - locked rises after the 5th sample edge.
   - step_err never pulses; err_count=0.
2. Wrap: while locked, drive 10001 (30) then 10000 (31) then 00000.
   - bin_out = 30, 31, 0.
   - wrap pulses exactly once, on the 0 sample.
   - locked stays 1.
3. Hold and gaps: while locked, repeat 00011 for three samples, with sample_en low for two intervening cycles.
   - bin_valid pulses 3 times; no step_err.
   - All outputs stable while sample_en is low.
4. Illegal jump: while locked at 3 (00010), drive 00111 (5).
   - step_err pulses; err_count=1; locked falls; bin_out=5.
   - Then drive 6,7,8,9: locked re-asserts after the 9 sample.
5. Saturation and reset: set ERR_W=2 and inject 5 illegal jumps.
   - err_count stops at 3.
   - Assert Clear on the same edge as a sample_en: the sample is ignored and all outputs return to 0.
   - The next sample (any value) produces bin_valid only, with no step_err.

Source files
------------

// File: rtl/gray_sequence_monitor_if.sv
// -----------------------------------------------------------------------------
// gray_sequence_monitor_if
//
// Groups the sample path and the status outputs of gray_sequence_monitor.
//   master : producer side (Gray counter / bench) -- drives sample_en, gray_in,
//            observes the decoded count and status.
//   slave  : the monitor itself -- samples sample_en, gray_in and drives
//            bin_out, bin_valid, step_err, wrap, locked, err_count.
//
// Bit ordering of gray_in / bin_out: bit 1 is the MSB, matching counter q.
// -----------------------------------------------------------------------------
interface gray_sequence_monitor_if #(
    parameter int N_Bits = 5,
    parameter int ERR_W  = 8
);
    logic              sample_en;
    logic [1:N_Bits]   gray_in;
    logic [1:N_Bits]   bin_out;
    logic              bin_valid;
    logic              step_err;
    logic              wrap;
    logic              locked;
    logic [ERR_W-1:0]  err_count;

    modport master (
        output sample_en, gray_in,
        input  bin_out, bin_valid, step_err, wrap, locked, err_count
    );

    modport slave (
        input  sample_en, gray_in,
        output bin_out, bin_valid, step_err, wrap, locked, err_count
    );
endinterface

// File: rtl/gray_sequence_monitor.sv
// -----------------------------------------------------------------------------
// gray_sequence_monitor
//
// Samples a Gray-coded count, decodes it to binary and verifies that each
// accepted sample advances by exactly one count (mod 2^N_Bits) or holds.
// Tracks lock (LOCK_LEN consecutive good advances), wrap-around from all ones
// to zero, and a saturating count of illegal steps.
//
// Ports:
//   Clock          rising-edge clock, shared with the Gray counter
//   Clear          synchronous active-high reset, priority over sampling
//   mon (slave)    sample_en, gray_in  -> sampled when sample_en is high
//                  bin_out             registered binary decode of last sample
//                  bin_valid           1-cycle pulse per accepted sample
//                  step_err            1-cycle pulse on an illegal step
//                  wrap                1-cycle pulse on advance all-ones -> 0
//                  locked              level, LOCK_LEN good advances since
//                                      last error or Clear
//                  err_count           saturating step-error count
// -----------------------------------------------------------------------------
module gray_sequence_monitor #(
    parameter int N_Bits   = 5,
    parameter int LOCK_LEN = 4,
    parameter int ERR_W    = 8
) (
    input  logic                    Clock,
    input  logic                    Clear,
    gray_sequence_monitor_if.slave  mon
);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_LEN);

    // Registered state
    state_t             state_q;
    logic [N_Bits-1:0]  prev_q;
    logic [N_Bits-1:0]  bin_q;
    logic [3:0]         good_cnt_q;
    logic               bin_valid_q;
    logic               step_err_q;
    logic               wrap_q;
    logic               locked_q;
    logic [ERR_W-1:0]   err_cnt_q;

    // Next-state values
    state_t             state_nx;
    logic [N_Bits-1:0]  prev_nx;
    logic [N_Bits-1:0]  bin_nx;
    logic [3:0]         good_cnt_nx;
    logic               bin_valid_nx;
    logic               step_err_nx;
    logic               wrap_nx;
    logic [ERR_W-1:0]   err_cnt_nx;

    // Decode and step classification
    logic [N_Bits-1:0]  gray_vec;
    logic [N_Bits-1:0]  bin_dec;
    logic [N_Bits-1:0]  step;
    logic               parity;
    logic               is_adv;
    logic               is_hold;
    logic               is_err;
    logic               is_wrap;

    // Binary bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        gray_vec = mon.gray_in;
        parity   = 1'b0;
        bin_dec  = '0;
        for (int i = N_Bits - 1; i >= 0; i--) begin
            parity     = parity ^ gray_vec[i];
            bin_dec[i] = parity;
        end
    end

    // Modular subtraction gives the step directly; wrap is just an advance
    // whose predecessor was all ones.
    assign step    = bin_dec - prev_q;
    assign is_adv  = (step == N_Bits'(1));
    assign is_hold = (step == '0);
    assign is_err  = !is_adv && !is_hold;
    assign is_wrap = is_adv && (prev_q == '1) && (bin_dec == '0);

    // Next-state / output logic
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        state_nx     = state_q;
        prev_nx      = prev_q;
        bin_nx       = bin_q;
        good_cnt_nx  = good_cnt_q;
        bin_valid_nx = 1'b0;
        step_err_nx  = 1'b0;
        wrap_nx      = 1'b0;
        err_cnt_nx   = err_cnt_q;

        if (mon.sample_en) begin
            // Every accepted sample re-references, including after an error.
            prev_nx      = bin_dec;
            bin_nx       = bin_dec;
            bin_valid_nx = 1'b1;

            if (state_q != SYNC && is_err) begin
                step_err_nx = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_nx = err_cnt_q + ERR_W'(1);
                end
            end

            unique case (state_q)
                SYNC: begin
                    // First sample after Clear is a pure load, no step check.
                    state_nx    = ACQUIRE;
                    good_cnt_nx = '0;
                end
                ACQUIRE: begin
                    if (is_adv) begin
                        wrap_nx     = is_wrap;
                        good_cnt_nx = good_cnt_q + 4'd1;
                        if (good_cnt_nx == LOCK_TARGET) begin
                            state_nx = LOCKED;
                        end
                    end else if (is_err) begin
                        good_cnt_nx = '0;
                    end
                end
                LOCKED: begin
                    if (is_adv) begin
                        wrap_nx = is_wrap;
                    end else if (is_err) begin
                        state_nx    = ACQUIRE;
                        good_cnt_nx = '0;
                    end
                end
                default: begin
                    state_nx    = SYNC;
                    good_cnt_nx = '0;
                end
            endcase
        end
    end

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            // NOTE: prev and bin_out are cleared along with the control state;
            // bin_out is a visible output that must read 0 after Clear.
            state_q     <= SYNC;
            prev_q      <= '0;
            bin_q       <= '0;
            good_cnt_q  <= '0;
            bin_valid_q <= 1'b0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
            locked_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_nx;
            prev_q      <= prev_nx;
            bin_q       <= bin_nx;
            good_cnt_q  <= good_cnt_nx;
            bin_valid_q <= bin_valid_nx;
            step_err_q  <= step_err_nx;
            wrap_q      <= wrap_nx;
            locked_q    <= (state_nx == LOCKED);
            err_cnt_q   <= err_cnt_nx;
        end
    end

    assign mon.bin_out   = bin_q;
    assign mon.bin_valid = bin_valid_q;
    assign mon.step_err  = step_err_q;
    assign mon.wrap      = wrap_q;
    assign mon.locked    = locked_q;
    assign mon.err_count = err_cnt_q;

endmodule
